// File: rtl/pipe_stage_chain_pkg.sv
// pipe_stage_chain_pkg: sizing helpers and control-bundle bit positions shared with the decoder.
package pipe_stage_chain_pkg;
    localparam int PIPE_MAX_STAGES = 8;
    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_MEMREAD    = 1;
    localparam int CTRL_MEMWRITE   = 2;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_JUMP       = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Sized for main plus skid registers so both builds share one width.
    function automatic int occ_w(input int stages);
        return clog2(2 * stages + 1);
    endfunction
endpackage

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: upstream/downstream handshake, flush and occupancy of a stage chain.
interface pipe_stage_chain_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int STAGES = 1
);
    import pipe_stage_chain_pkg::*;
    localparam int OCC_W = occ_w(STAGES);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;
    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );
    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_chain_slot.sv
// pipe_stage_chain_slot: one register slot of the chain; with PIPE_SKID_EN it gains a skid
// register so up_ready_o comes straight from a flop.
module pipe_stage_chain_slot #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o
);
    logic              v_q, v_d;
    logic [CTRL_W-1:0] c_q, c_d;
    logic [DATA_W-1:0] d_q, d_d;
    assign dn_valid_o = v_q;
    assign dn_ctrl_o  = c_q;
    assign dn_data_o  = d_q;
`ifdef PIPE_SKID_EN
    logic              sv_q, sv_d, acc, adv;
    logic [CTRL_W-1:0] sc_q, sc_d;
    logic [DATA_W-1:0] sd_q, sd_d;
    // Main refills from skid first so entry order is kept.
    always_comb begin
        up_ready_o = !sv_q;
        acc        = up_valid_i && !sv_q;
        adv        = !v_q || dn_ready_i;
        v_d        = adv ? (sv_q || acc) : v_q;
        c_d        = !adv ? c_q : sv_q ? sc_q : acc ? up_ctrl_i : '0;
        d_d        = !adv ? d_q : sv_q ? sd_q : acc ? up_data_i : d_q;
        sv_d       = adv ? 1'b0 : (sv_q || acc);
        sc_d       = adv ? '0 : acc ? up_ctrl_i : sc_q;
        sd_d       = (!adv && acc) ? up_data_i : sd_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            v_q  <= 1'b0;
            c_q  <= '0;
            d_q  <= '0;
            sv_q <= 1'b0;
            sc_q <= '0;
            sd_q <= '0;
        end else if (flush_i) begin
            v_q  <= 1'b0;
            c_q  <= '0;
            sv_q <= 1'b0;
            sc_q <= '0;
        end else begin
            v_q  <= v_d;
            c_q  <= c_d;
            d_q  <= d_d;
            sv_q <= sv_d;
            sc_q <= sc_d;
            sd_q <= sd_d;
        end
    end
`else
    always_comb begin
        up_ready_o = !v_q || dn_ready_i;
        v_d        = up_ready_o ? up_valid_i : v_q;
        c_d        = !up_ready_o ? c_q : up_valid_i ? up_ctrl_i : '0;
        d_d        = (up_ready_o && up_valid_i) ? up_data_i : d_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            v_q <= 1'b0;
            c_q <= '0;
            d_q <= '0;
        end else if (flush_i) begin
            v_q <= 1'b0;
            c_q <= '0;
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            d_q <= d_d;
        end
    end
`endif
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES valid/ready register slots with flush and occupancy count.
// Define PIPE_SKID_EN to give every slot a skid register and a registered ready path.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int STAGES = 1
) (
    input logic               clock,
    input logic               reset,
    pipe_stage_chain_if.slave bus
);
    localparam int OCC_W = occ_w(STAGES);
    logic [OCC_W-1:0] occ_q, occ_d;
    if (STAGES < 1 || STAGES > PIPE_MAX_STAGES) begin : bad_stages
        $error("pipe_stage_chain: STAGES out of range");
    end
    for (genvar k = 0; k < STAGES; k++) begin : g
        logic              up_v, up_r, dn_v, dn_r;
        logic [CTRL_W-1:0] up_c, dn_c;
        logic [DATA_W-1:0] up_d, dn_d;
        if (k == 0) begin : head
            assign up_v         = bus.in_valid;
            assign up_c         = bus.in_ctrl;
            assign up_d         = bus.in_data;
            assign bus.in_ready = up_r;
        end else begin : link
            assign up_v = g[k-1].dn_v;
            assign up_c = g[k-1].dn_c;
            assign up_d = g[k-1].dn_d;
        end
        // Ready of each slot comes from its own successor, keeping the chain acyclic per signal.
        if (k == STAGES - 1) begin : tail
            assign dn_r          = bus.out_ready;
            assign bus.out_valid = dn_v;
            assign bus.out_ctrl  = dn_c;
            assign bus.out_data  = dn_d;
        end else begin : feed
            assign dn_r = g[k+1].up_r;
        end
        pipe_stage_chain_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot (
            .clock      (clock),
            .reset      (reset),
            .flush_i    (bus.flush),
            .up_valid_i (up_v),
            .up_ready_o (up_r),
            .up_ctrl_i  (up_c),
            .up_data_i  (up_d),
            .dn_valid_o (dn_v),
            .dn_ready_i (dn_r),
            .dn_ctrl_o  (dn_c),
            .dn_data_o  (dn_d)
        );
    end
    always_comb occ_d = occ_q + OCC_W'(bus.in_valid && bus.in_ready)
                              - OCC_W'(bus.out_valid && bus.out_ready);
    always_ff @(posedge clock) occ_q <= (reset || bus.flush) ? '0 : occ_d;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: vector table, corner-case sequences and a random run, all
// checked against an in-order scoreboard of accepted entries.
module tb_pipe_stage_chain;
    import pipe_stage_chain_pkg::*;
    localparam int CW = 8;
    localparam int DW = 32;
    localparam int ST = 3;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2 * ST;
`else
    localparam int CAP = ST;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipe_stage_chain_if #(.CTRL_W(CW), .DATA_W(DW), .STAGES(ST)) bus ();
    pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .STAGES(ST)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          e_ir;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [DW-1:0] e_od;
        logic [2:0]    e_occ;
    } vec_t;

    ent_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_ctrl   = ic;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // One clock: record handshakes at the negedge, then step past the posedge.
    task automatic cycle();
        ent_t e;
        @(negedge clock);
        if (reset || bus.flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_ctrl", 64'(bus.out_ctrl), 64'(e.c));
                    chk("sb_data", 64'(bus.out_data), 64'(e.d));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back({bus.in_ctrl, bus.in_data});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int n);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < n && sb.size() != 0; i++) cycle();
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_occ", 64'(bus.occupancy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[9];
        int   idx;
        logic rdy, seen;
        tv[0] = '{1'b1, 8'hA1, 32'h101, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h000, 3'd1};
        tv[1] = '{1'b1, 8'hA2, 32'h102, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h000, 3'd2};
        tv[2] = '{1'b1, 8'hA3, 32'h103, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 32'h101, 3'd3};
        tv[3] = '{1'b1, 8'hA4, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 32'h101, 3'd3};
        tv[4] = '{1'b1, 8'hA4, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 32'h102, 3'd3};
        tv[5] = '{1'b0, 8'h00, 32'h000, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 32'h103, 3'd2};
        tv[6] = '{1'b1, 8'hA5, 32'h105, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 32'h103, 3'd3};
        tv[7] = '{1'b1, 8'hA6, 32'h106, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 32'h103, 3'd0};
        tv[8] = '{1'b0, 8'h00, 32'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h103, 3'd0};

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        reset = 1'b0;
        #1 chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

`ifndef PIPE_SKID_EN
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].iv, tv[i].ic, tv[i].id, tv[i].ordy, tv[i].fl);
            #1 chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(tv[i].e_ir));
            cycle();
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(tv[i].e_ov));
            chk($sformatf("vec%0d_out_ctrl", i), 64'(bus.out_ctrl), 64'(tv[i].e_oc));
            chk($sformatf("vec%0d_out_data", i), 64'(bus.out_data), 64'(tv[i].e_od));
            chk($sformatf("vec%0d_occ", i), 64'(bus.occupancy), 64'(tv[i].e_occ));
        end
`endif

        // Back-to-back stream: first output after STAGES edges, occupancy then steady.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'hA5, DW'(i + 1), 1'b1, 1'b0);
            cycle();
            chk($sformatf("stream%0d_out_valid", i), 64'(bus.out_valid), 64'(i + 1 >= ST));
            if (i + 1 == ST) chk("stream_first_data", 64'(bus.out_data), 64'd1);
            if (i + 1 >= ST) chk($sformatf("stream%0d_occ", i), 64'(bus.occupancy), 64'(ST));
        end
        drain(10);

        // Stall: accept until full, then ready drops; nothing lost on release.
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'hB0, 32'h200 + DW'(idx), 1'b0, 1'b0);
            #1 rdy = bus.in_ready;
            cycle();
            if (rdy) idx++;
        end
        chk("stall_accepted", 64'(idx), 64'(CAP));
        chk("stall_occ", 64'(bus.occupancy), 64'(CAP));
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        drain(20);

        // Flush with the chain full and an entry offered.
        for (int i = 0; i < ST; i++) begin
            drive(1'b1, 8'hC0 + CW'(i), 32'h300 + DW'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 8'hDE, 32'hDEAD, 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            seen |= bus.out_valid;
        end
        chk("flush_no_reappear", 64'(seen), 64'd0);

        // Flush together with an emit: the emitted entry is squashed.
        for (int i = 0; i < ST; i++) begin
            drive(1'b1, 8'hD0 + CW'(i), 32'h400 + DW'(i), 1'b1, 1'b0);
            cycle();
        end
        chk("squash_pre_out_valid", 64'(bus.out_valid), 64'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("squash_out_valid", 64'(bus.out_valid), 64'd0);
        chk("squash_occ", 64'(bus.occupancy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seen |= bus.out_valid;
        end
        chk("squash_no_reappear", 64'(seen), 64'd0);

        // Reset with two entries in flight zeroes data as well.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hE0 + CW'(i), 32'h500 + DW'(i), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        chk("midrst_out_data", 64'(bus.out_data), 64'd0);
        chk("midrst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("midrst_occ", 64'(bus.occupancy), 64'd0);
        reset = 1'b0;
        #1 chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
`ifdef PIPE_SKID_EN
            #1 rdy = bus.in_ready;
            bus.out_ready = !bus.out_ready;
            #1 chk("rand_in_ready_registered", 64'(bus.in_ready), 64'(rdy));
            bus.out_ready = !bus.out_ready;
`endif
            cycle();
            chk("rand_occ", 64'(bus.occupancy), 64'(sb.size()));
            if (!bus.out_valid) chk("rand_idle_ctrl", 64'(bus.out_ctrl), 64'd0);
        end
        drain(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
